// File: rtl/aes_output_interface.sv
// Byte serialiser for the AES engine result: captures the ciphertext on a rising
// engine_done and streams it out one byte per valid/ready handshake.
module aes_output_interface #(
    parameter int DATA_W    = 128,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] ciphertext_in,
    input  logic              engine_done,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              tx_done,
    output logic              overrun
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic [7:0]          r_dout;
    logic                r_dout_valid;
    logic                r_busy;
    logic                r_tx_done;
    logic                r_overrun;
    logic                r_done_q;

    logic                w_done_rise;
    logic                w_handshake;
    logic                w_last;
    logic [DATA_W-1:0]   w_next_shift;

    // Byte that sits at the send end of a shift-register image.
    function automatic logic [7:0] send_byte(input logic [DATA_W-1:0] v);
        if (MSB_FIRST) begin
            send_byte = v[DATA_W-1 -: 8];
        end else begin
            send_byte = v[7:0];
        end
    endfunction

    // Move the next byte into the send position.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        if (MSB_FIRST) begin
            advance = v << 4'd8;
        end else begin
            advance = v >> 4'd8;
        end
    endfunction

    assign w_done_rise  = engine_done & ~r_done_q;
    assign w_handshake  = r_dout_valid & dout_ready;
    assign w_last       = (r_cnt == LAST_CNT);
    assign w_next_shift = advance(r_shift);

    // Serialiser FSM; done_q resets high so a done already asserted at reset release is ignored.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_done    <= 1'b0;
            r_overrun    <= 1'b0;
            r_done_q     <= 1'b1;
        end else begin
            r_done_q  <= engine_done;
            r_overrun <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    r_tx_done <= 1'b0;
                    if (w_done_rise) begin
                        r_shift      <= ciphertext_in;
                        r_cnt        <= '0;
                        r_dout       <= send_byte(ciphertext_in);
                        r_dout_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEND;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // A new result cannot be accepted mid-stream; flag and drop it.
                    r_overrun <= w_done_rise;
                    if (w_handshake) begin
                        if (w_last) begin
                            r_dout       <= 8'h00;
                            r_dout_valid <= 1'b0;
                            r_busy       <= 1'b0;
                            r_tx_done    <= 1'b1;
                            r_state      <= ST_FIN;
                        end else begin
                            r_shift <= w_next_shift;
                            r_dout  <= send_byte(w_next_shift);
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_dout       <= 8'h00;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_tx_done    <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign tx_done    = r_tx_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_aes_output_interface.sv
// Self-checking bench for aes_output_interface: MSB-first and LSB-first instances
// checked against a byte-list reference built directly from the ciphertext.
module tb_aes_output_interface;

    logic         clk = 1'b0;
    logic         rst_;
    logic [127:0] ct;
    logic         done;
    logic         ready;

    logic [7:0]   dout,   l_dout;
    logic         dout_valid, l_dout_valid;
    logic         busy,   l_busy;
    logic         tx_done, l_tx_done;
    logic         overrun, l_overrun;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_A    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B    = 128'h8899aabbccddeeff0011223344556677;

    always #5 clk = ~clk;

    aes_output_interface #(.DATA_W(128), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_(rst_), .ciphertext_in(ct), .engine_done(done),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(ready),
        .busy(busy), .tx_done(tx_done), .overrun(overrun));

    aes_output_interface #(.DATA_W(128), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_(rst_), .ciphertext_in(ct), .engine_done(done),
        .dout(l_dout), .dout_valid(l_dout_valid), .dout_ready(ready),
        .busy(l_busy), .tx_done(l_tx_done), .overrun(l_overrun));

    // Reference: k-th byte on the wire for a given ciphertext and byte order.
    function automatic logic [7:0] ref_byte(input logic [127:0] v, input int k, input bit msb);
        if (msb) return v[127-8*k -: 8];
        else     return v[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [127:0] v);
        done  = 1'b0;
        ready = 1'b1;
        tick();
        ct   = v;
        done = 1'b1;
    endtask

    // Drives ready per mode, records accepted bytes until tx_done or budget exhausted.
    task automatic collect(input int mode, input int lower_at, input int raise_at, input bit scramble,
                           output logic [7:0] got [$], output int done_pulses,
                           output int ovr_pulses, output int hold_err);
        logic       pv, pr;
        logic [7:0] pd;
        got = {};
        done_pulses = 0; ovr_pulses = 0; hold_err = 0;
        for (int c = 0; c < 200; c++) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = c[0];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (dout_valid && ready) got.push_back(dout);
            if (got.size() == lower_at) done = 1'b0;
            if (got.size() == raise_at) done = 1'b1;
            pv = dout_valid; pd = dout; pr = ready;
            tick();
            if (scramble) ct = {$urandom, $urandom, $urandom, $urandom};
            if (pv && !pr && (!dout_valid || dout !== pd)) hold_err++;
            if (overrun) ovr_pulses++;
            if (tx_done) begin
                done_pulses++;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic bad;
        rst_ = 1'b1; done = 1'b1; ready = 1'b0; ct = CT_FIPS;
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, busy, tx_done, overrun} !== 12'h000)
            $display("FAIL reset_outputs: got %h expected 000", {dout, dout_valid, busy, tx_done, overrun});
        checks++;
        if ({l_dout, l_dout_valid, l_busy, l_tx_done, l_overrun} !== 12'h000)
            $display("FAIL reset_outputs_lsb: got %h expected 000", {l_dout, l_dout_valid, l_busy, l_tx_done, l_overrun});
        if ({dout, dout_valid, busy, tx_done, overrun} !== 12'h000) errors++;
        if ({l_dout, l_dout_valid, l_busy, l_tx_done, l_overrun} !== 12'h000) errors++;
        tick(); tick();
        rst_ = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dout_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_high_done_ignored: got valid=%b busy=%b expected 0 0", dout_valid, busy);
        end
    endtask

    task automatic test_fips();
        start_stream(CT_FIPS);
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b1 || busy !== 1'b1 || tx_done !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL fips_ctrl[%0d]: got v=%b b=%b d=%b o=%b expected 1 1 0 0", k, dout_valid, busy, tx_done, overrun);
            end
            checks++;
            if (dout !== ref_byte(CT_FIPS, k, 1'b1)) begin
                errors++;
                $display("FAIL fips_byte[%0d]: got %h expected %h", k, dout, ref_byte(CT_FIPS, k, 1'b1));
            end
            checks++;
            if (l_dout !== ref_byte(CT_FIPS, k, 1'b0)) begin
                errors++;
                $display("FAIL lsb_byte[%0d]: got %h expected %h", k, l_dout, ref_byte(CT_FIPS, k, 1'b0));
            end
        end
        tick();
        checks++;
        if (tx_done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL fips_finish: got d=%b v=%b b=%b dout=%h expected 1 0 0 00", tx_done, dout_valid, busy, dout);
        end
        tick();
        checks++;
        if (tx_done !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse: got d=%b v=%b b=%b expected 0 0 0", tx_done, dout_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]   got [$];
        logic [127:0] v;
        int dp, op, he, bad;
        for (int it = 0; it < 4; it++) begin
            v = (it == 0) ? CT_FIPS : {$urandom, $urandom, $urandom, $urandom};
            start_stream(v);
            collect((it == 0) ? 1 : 2, -1, -1, 1'b1, got, dp, op, he);
            bad = 0;
            for (int k = 0; k < got.size() && k < 16; k++)
                if (got[k] !== ref_byte(v, k, 1'b1)) bad++;
            checks++;
            if (got.size() != 16 || bad != 0) begin
                errors++;
                $display("FAIL bp_stream[%0d]: got %0d bytes %0d wrong expected 16 bytes 0 wrong", it, got.size(), bad);
            end
            checks++;
            if (he != 0 || dp != 1 || op != 0) begin
                errors++;
                $display("FAIL bp_ctrl[%0d]: got hold_err=%0d done=%0d ovr=%0d expected 0 1 0", it, he, dp, op);
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] got [$];
        int dp, op, he, bad, lo, hi;
        for (int it = 0; it < 2; it++) begin
            lo = (it == 0) ? 5 : 15;
            hi = lo + 1;
            start_stream(CT_FIPS);
            collect(0, lo, hi, 1'b1, got, dp, op, he);
            bad = 0;
            for (int k = 0; k < got.size() && k < 16; k++)
                if (got[k] !== ref_byte(CT_FIPS, k, 1'b1)) bad++;
            checks++;
            if (got.size() != 16 || bad != 0 || dp != 1) begin
                errors++;
                $display("FAIL ovr_stream[%0d]: got %0d bytes %0d wrong done=%0d expected 16 0 1", it, got.size(), bad, dp);
            end
            checks++;
            if (op != 1) begin
                errors++;
                $display("FAIL ovr_pulse[%0d]: got %0d pulses expected 1", it, op);
            end
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ovr_no_restart[%0d]: got %0d active cycles expected 0", it, bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]   got [$];
        logic [127:0] v;
        int n, dp, op, he, bad;
        v = {$urandom, $urandom, $urandom, $urandom};
        start_stream(v);
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (dout_valid && ready) n++;
            tick();
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rstmid_progress: got %0d bytes expected 5", n);
        end
        rst_ = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, busy, tx_done, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h expected 000", {dout, dout_valid, busy, tx_done, overrun});
        end
        tick();
        rst_ = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dout_valid !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_no_tx: got %0d active cycles expected 0", bad);
        end
        start_stream(v);
        collect(0, -1, -1, 1'b1, got, dp, op, he);
        bad = 0;
        for (int k = 0; k < got.size() && k < 16; k++)
            if (got[k] !== ref_byte(v, k, 1'b1)) bad++;
        checks++;
        if (got.size() != 16 || bad != 0 || dp != 1) begin
            errors++;
            $display("FAIL rstmid_restart: got %0d bytes %0d wrong done=%0d expected 16 0 1", got.size(), bad, dp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ga [$];
        logic [7:0] gb [$];
        int dpa, opa, hea, dpb, opb, heb, bad;
        start_stream(CT_A);
        collect(0, 16, -1, 1'b1, ga, dpa, opa, hea);
        ct   = CT_B;
        done = 1'b1;
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== ref_byte(CT_B, 0, 1'b1)) begin
            errors++;
            $display("FAIL b2b_gap: got v=%b dout=%h expected 1 %h", dout_valid, dout, ref_byte(CT_B, 0, 1'b1));
        end
        collect(0, -1, -1, 1'b1, gb, dpb, opb, heb);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < ga.size() && ga[k] !== ref_byte(CT_A, k, 1'b1)) bad++;
            if (k < gb.size() && gb[k] !== ref_byte(CT_B, k, 1'b1)) bad++;
        end
        checks++;
        if (ga.size() != 16 || gb.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL b2b_streams: got %0d+%0d bytes %0d wrong expected 16+16 0", ga.size(), gb.size(), bad);
        end
        checks++;
        if (dpa != 1 || dpb != 1 || opa != 0 || opb != 0) begin
            errors++;
            $display("FAIL b2b_ctrl: got done=%0d,%0d ovr=%0d,%0d expected 1,1 0,0", dpa, dpb, opa, opb);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
